cmb_toggle_monitor: RTL
=======================

Name: cmb_toggle_monitor

Overview:
- Downstream activity monitor for the 4-output cmb benchmark (q, r, s, t).
- Accepts one output vector per valid/ready transfer and counts per-output bit toggles between consecutive accepted vectors.
- Every WIN_LEN accepted vectors it emits one report through a single-entry valid/ready buffer.
- The report gives switching activity for power-aware synthesis evaluation.

Parameters:
- WIN_LEN, 16, accepted samples per report window (≥2).
- CNT_W, $clog2(WIN_LEN+1), width of each per-bit toggle count. Derived; do not override.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of window state.
- in_valid  input  1  sample valid.
- in_ready  output  1  sample accepted when in_valid&&in_ready.
- in_data  input  4  {q,r,s,t}: bit3=q, bit2=r, bit1=s, bit0=t.
- rpt_valid  output  1  report available.
- rpt_ready  input  1  report consumed when rpt_valid&&rpt_ready.
- rpt_tgl  output  4*CNT_W  per-bit toggle counts, slice [i*CNT_W +: CNT_W] belongs to in_data[i].
- rpt_tot  output  CNT_W+2  sum of the four toggle counts.

Behaviour:
- Reset (rst_n=0, async) and clr (sync) both force:
  - state RUN, in_ready=1, rpt_valid=0, rpt_tgl=0, rpt_tot=0;
  - working counters=0, sample count=0, has_prev=0, prev=0.
- clr also discards any pending report. clr has priority over all same-cycle transfers.
- State machine (2 states):
  - RUN: in_ready=1.
  - HOLD: in_ready=0.
- On each accepted sample:
  - If has_prev=1, each working counter i increments when in_data[i]!=prev[i].
  - If has_prev=0, no increment; has_prev is then set to 1.
  - prev<=in_data; sample count increments.
- The first sample after reset/clr counts toward the window but contributes no toggles.
- prev persists across window boundaries. The boundary toggle is credited to the new window.
- Window close: the sample that brings the count to WIN_LEN closes the window. The counters include that sample's toggles. Then:
  - if the report buffer is free (rpt_valid=0, or rpt_valid&&rpt_ready this cycle): next cycle rpt_valid=1 with the closing counts; working counters and sample count zero; stay RUN.
  - otherwise: go to HOLD. Working counters freeze at the closing values.
- HOLD: when rpt_valid&&rpt_ready, the held counts load into the buffer the next cycle (rpt_valid stays 1), counters zero, and the state returns to RUN.
- No sample is ever lost or double-counted. Backpressure costs exactly one stalled window.
- Report latency: rpt_valid rises the cycle after the closing sample is accepted (buffer free).
- rpt_tot = zero-extended sum of the 4 counts. Maximum 4*WIN_LEN, so no overflow.
- Per-bit counts saturate mathematically at WIN_LEN; no wrap is possible.
- Report outputs are stable while rpt_valid=1 and rpt_ready=0.
- When rpt_valid&&rpt_ready with no new report loading, rpt_valid drops next cycle. Data holds its last value.

Optional Feature:
- Macro CMB_TGL_ONES_EN.
- When defined:
  - extra output rpt_ones (4*CNT_W) reports per-bit counts of accepted samples with in_data[i]=1 in the window (static probability);
  - these counts are buffered, held and cleared exactly like rpt_tgl.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package cmb_mon_pkg holds:
  - bit index constants IDX_Q=3, IDX_R=2, IDX_S=1, IDX_T=0;
  - state enum {RUN, HOLD};
  - a function computing CNT_W from WIN_LEN.
- Sub-module cmb_tgl_ctr: one per-bit counter with inc, clr, load-zero and hold. Instantiated 4x (8x with CMB_TGL_ONES_EN).

Test Plan:
- Basic window, WIN_LEN=4, rpt_ready=1, samples 0x0,0xF,0xF,0x5 → one cycle later rpt_valid=1, rpt_tgl q=2, r=1, s=2, t=1, rpt_tot=6.
- Boundary carry: continue with 0xA,0xA,0xA,0xA → rpt_tgl all 1, rpt_tot=4 (only the 0x5→0xA toggle counts).
- Backpressure, rpt_ready=0:
  - two full windows → in_ready=0 after the 8th accepted sample, held in HOLD;
  - raise rpt_ready one cycle → the second report appears next cycle and in_ready returns to 1.
- Simultaneous: rpt_ready=1 in the same cycle as a window-closing sample while rpt_valid=1 → new report loads, in_ready never drops.
- clr mid-window after 2 samples, then 4 samples 0x1,0x0,0x1,0x0 → rpt_tgl t=3, others 0, rpt_tot=3; a pending report is dropped.
- Async reset asserted mid-HOLD → all outputs 0 immediately, in_ready=1 after release. With CMB_TGL_ONES_EN, window 0xF,0x1,0x1,0x0 → rpt_ones q=1, r=1, s=1, t=3.

Source files
------------

// File: rtl/cmb_mon_pkg.sv
// Shared definitions for the cmb toggle monitor: output bit positions,
// controller states and the per-bit counter width derivation.
package cmb_mon_pkg;

  localparam int IDX_Q = 3;
  localparam int IDX_R = 2;
  localparam int IDX_S = 1;
  localparam int IDX_T = 0;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // A per-bit count never exceeds the window length, so it needs to hold 0..win_len.
  function automatic int cnt_w_f(input int win_len);
    return $clog2(win_len + 1);
  endfunction

endpackage

// File: rtl/cmb_tgl_ctr.sv
// Single per-bit event counter for the toggle monitor: increment, synchronous
// clear, load-zero at report hand-off, and hold while a window is parked.
module cmb_tgl_ctr
  import cmb_mon_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             zero,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  // Value including this cycle's event; the report captures it on the closing sample.
  assign cnt_nxt = cnt + CNT_W'(inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || zero) begin
      cnt <= '0;
    end else if (!hold && inc) begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/cmb_toggle_monitor.sv
// Per-output toggle activity monitor for the cmb benchmark outputs {q,r,s,t}.
// Define CMB_TGL_ONES_EN to add rpt_ones (per-bit count of samples equal to 1).
//
// state | meaning
// RUN   | accepting samples, in_ready=1
// HOLD  | window closed while report buffer busy; counters parked, in_ready=0
module cmb_toggle_monitor
  import cmb_mon_pkg::*;
#(
  parameter  int WIN_LEN = 16,
  localparam int CNT_W   = cnt_w_f(WIN_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_data,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [4*CNT_W-1:0] rpt_tgl,
  output logic [CNT_W+1:0]   rpt_tot
`ifdef CMB_TGL_ONES_EN
  ,
  output logic [4*CNT_W-1:0] rpt_ones
`endif
);

  state_t             state;
  logic [CNT_W-1:0]   smp_cnt;
  logic [3:0]         prev;
  logic               has_prev;
  logic               accept;
  logic               closing;
  logic               buf_free;
  logic               close_load;
  logic               hold_load;
  logic               ctr_zero;
  logic               hold_st;
  logic [3:0]         tgl_inc;
  logic [4*CNT_W-1:0] tgl_cnt;
  logic [4*CNT_W-1:0] tgl_nxt;
  logic [4*CNT_W-1:0] tgl_src;

  function automatic logic [CNT_W+1:0] tot_f(input logic [4*CNT_W-1:0] v);
    logic [CNT_W+1:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s = s + (CNT_W+2)'(v[i*CNT_W +: CNT_W]);
    end
    return s;
  endfunction

  assign accept     = in_valid && in_ready;
  assign closing    = accept && (smp_cnt == CNT_W'(WIN_LEN - 1));
  assign buf_free   = !rpt_valid || rpt_ready;
  assign close_load = closing && buf_free;
  assign hold_load  = (state == HOLD) && rpt_valid && rpt_ready;
  assign ctr_zero   = close_load || hold_load;
  assign hold_st    = (state == HOLD);
  assign tgl_inc    = (accept && has_prev) ? (in_data ^ prev) : 4'b0000;
  // Closing sample's own event is not yet in the register, so take the next value.
  assign tgl_src    = close_load ? tgl_nxt : tgl_cnt;

  for (genvar i = 0; i < 4; i++) begin : g_tgl
    cmb_tgl_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .inc     (tgl_inc[i]),
      .zero    (ctr_zero),
      .hold    (hold_st),
      .cnt     (tgl_cnt[i*CNT_W +: CNT_W]),
      .cnt_nxt (tgl_nxt[i*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      in_ready <= 1'b1;
      smp_cnt  <= '0;
      prev     <= '0;
      has_prev <= 1'b0;
    end else if (clr) begin
      state    <= RUN;
      in_ready <= 1'b1;
      smp_cnt  <= '0;
      prev     <= '0;
      has_prev <= 1'b0;
    end else begin
      if (accept) begin
        prev     <= in_data;
        has_prev <= 1'b1;
        smp_cnt  <= closing ? '0 : smp_cnt + 1'b1;
      end
      case (state)
        RUN: begin
          if (closing && !buf_free) begin
            state    <= HOLD;
            in_ready <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_load) begin
            state    <= RUN;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_valid <= 1'b0;
      rpt_tgl   <= '0;
      rpt_tot   <= '0;
    end else if (clr) begin
      rpt_valid <= 1'b0;
      rpt_tgl   <= '0;
      rpt_tot   <= '0;
    end else if (close_load || hold_load) begin
      rpt_valid <= 1'b1;
      rpt_tgl   <= tgl_src;
      rpt_tot   <= tot_f(tgl_src);
    end else if (rpt_valid && rpt_ready) begin
      rpt_valid <= 1'b0;
    end
  end

`ifdef CMB_TGL_ONES_EN
  logic [3:0]         ones_inc;
  logic [4*CNT_W-1:0] ones_cnt;
  logic [4*CNT_W-1:0] ones_nxt;

  assign ones_inc = accept ? in_data : 4'b0000;

  for (genvar i = 0; i < 4; i++) begin : g_ones
    cmb_tgl_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .inc     (ones_inc[i]),
      .zero    (ctr_zero),
      .hold    (hold_st),
      .cnt     (ones_cnt[i*CNT_W +: CNT_W]),
      .cnt_nxt (ones_nxt[i*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_ones <= '0;
    end else if (clr) begin
      rpt_ones <= '0;
    end else if (close_load) begin
      rpt_ones <= ones_nxt;
    end else if (hold_load) begin
      rpt_ones <= ones_cnt;
    end
  end
`else
  // Static-probability counters are not built in this configuration.
`endif

endmodule
